// File: rtl/wb_unit.sv
// Writeback stage: holds one retiring instruction, waits for load data,
// then drives the regfile write port and the difftest commit record.
module wb_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid_i,
    output logic        mem_ready_o,
    input  logic [63:0] mem_pc_i,
    input  logic [31:0] mem_inst_i,
    input  logic [4:0]  mem_rd_i,
    input  logic        mem_rd_wen_i,
    input  logic [63:0] mem_result_i,
    input  logic        mem_is_load_i,
    input  logic [1:0]  mem_ld_size_i,
    input  logic        mem_ld_unsigned_i,
    input  logic [2:0]  mem_addr_lo_i,
    input  logic        dmem_rvalid_i,
    input  logic [63:0] dmem_rdata_i,
    output logic [4:0]  rf_waddr_o,
    output logic [63:0] rf_wdata_o,
    output logic        rf_wen_o,
    output logic        pending_valid_o,
    output logic [4:0]  pending_rd_o,
    output logic        commit_valid_o,
    output logic [63:0] commit_pc_o,
    output logic [31:0] commit_inst_o,
    output logic        commit_wen_o,
    output logic [4:0]  commit_wdest_o,
    output logic [63:0] commit_wdata_o
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_LOAD,
        WRITE
    } state_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic [4:0]  rd;
        logic        wen;
        logic [63:0] result;
        logic        is_load;
        logic [1:0]  size;
        logic        uns;
        logic [2:0]  addr_lo;
    } entry_t;

    state_t state_q, state_d;
    entry_t ent_q, ent_d;

    logic        xfer;
    logic        busy;
    logic        writes_rd;
    logic [63:0] sh_b, sh_h, sh_w;
    logic [63:0] ld_data;

    // Ready is forced low while reset is held so the memory stage cannot hand off.
    assign mem_ready_o = ~rst & (state_q != WAIT_LOAD);
    assign xfer        = mem_valid_i & mem_ready_o;
    assign busy        = (state_q != IDLE);
    assign writes_rd   = ent_q.wen & (ent_q.rd != 5'd0);

    always_comb begin
        sh_b    = dmem_rdata_i >> {ent_q.addr_lo, 3'b000};
        sh_h    = dmem_rdata_i >> {ent_q.addr_lo[2:1], 4'b0000};
        sh_w    = dmem_rdata_i >> {ent_q.addr_lo[2], 5'b00000};
        ld_data = dmem_rdata_i;
        unique case (ent_q.size)
            2'd0: ld_data = ent_q.uns ? {56'd0, sh_b[7:0]}
                                      : {{56{sh_b[7]}}, sh_b[7:0]};
            2'd1: ld_data = ent_q.uns ? {48'd0, sh_h[15:0]}
                                      : {{48{sh_h[15]}}, sh_h[15:0]};
            2'd2: ld_data = ent_q.uns ? {32'd0, sh_w[31:0]}
                                      : {{32{sh_w[31]}}, sh_w[31:0]};
            default: ld_data = dmem_rdata_i;
        endcase
    end

    always_comb begin
        state_d = state_q;
        ent_d   = ent_q;
        unique case (state_q)
            IDLE, WRITE: begin
                if (xfer) begin
                    ent_d.pc      = mem_pc_i;
                    ent_d.inst    = mem_inst_i;
                    ent_d.rd      = mem_rd_i;
                    ent_d.wen     = mem_rd_wen_i;
                    ent_d.result  = mem_result_i;
                    ent_d.is_load = mem_is_load_i;
                    ent_d.size    = mem_ld_size_i;
                    ent_d.uns     = mem_ld_unsigned_i;
                    ent_d.addr_lo = mem_addr_lo_i;
                    state_d       = mem_is_load_i ? WAIT_LOAD : WRITE;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_LOAD: begin
                if (dmem_rvalid_i) begin
                    ent_d.result = ld_data;
                    state_d      = WRITE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ent_q   <= '0;
        end else begin
            state_q <= state_d;
            ent_q   <= ent_d;
        end
    end

    assign rf_waddr_o      = busy ? ent_q.rd : 5'd0;
    assign rf_wdata_o      = busy ? ent_q.result : 64'd0;
    assign rf_wen_o        = (state_q == WRITE) & writes_rd;
    assign pending_valid_o = busy & writes_rd;
    assign pending_rd_o    = pending_valid_o ? ent_q.rd : 5'd0;

    assign commit_valid_o = (state_q == WRITE);
    assign commit_pc_o    = commit_valid_o ? ent_q.pc : 64'd0;
    assign commit_inst_o  = commit_valid_o ? ent_q.inst : 32'd0;
    assign commit_wen_o   = rf_wen_o;
    assign commit_wdest_o = commit_valid_o ? ent_q.rd : 5'd0;
    assign commit_wdata_o = commit_valid_o ? ent_q.result : 64'd0;

endmodule

// File: tb/tb_wb_unit.sv
// Directed bench for wb_unit: ALU writeback, load extraction,
// load wait, x0 retire and reset during a pending load.
module tb_wb_unit;

    logic        clk;
    logic        rst;
    logic        mem_valid_i;
    logic        mem_ready_o;
    logic [63:0] mem_pc_i;
    logic [31:0] mem_inst_i;
    logic [4:0]  mem_rd_i;
    logic        mem_rd_wen_i;
    logic [63:0] mem_result_i;
    logic        mem_is_load_i;
    logic [1:0]  mem_ld_size_i;
    logic        mem_ld_unsigned_i;
    logic [2:0]  mem_addr_lo_i;
    logic        dmem_rvalid_i;
    logic [63:0] dmem_rdata_i;
    logic [4:0]  rf_waddr_o;
    logic [63:0] rf_wdata_o;
    logic        rf_wen_o;
    logic        pending_valid_o;
    logic [4:0]  pending_rd_o;
    logic        commit_valid_o;
    logic [63:0] commit_pc_o;
    logic [31:0] commit_inst_o;
    logic        commit_wen_o;
    logic [4:0]  commit_wdest_o;
    logic [63:0] commit_wdata_o;

    int checks = 0;
    int errors = 0;

    wb_unit dut (
        .clk              (clk),
        .rst              (rst),
        .mem_valid_i      (mem_valid_i),
        .mem_ready_o      (mem_ready_o),
        .mem_pc_i         (mem_pc_i),
        .mem_inst_i       (mem_inst_i),
        .mem_rd_i         (mem_rd_i),
        .mem_rd_wen_i     (mem_rd_wen_i),
        .mem_result_i     (mem_result_i),
        .mem_is_load_i    (mem_is_load_i),
        .mem_ld_size_i    (mem_ld_size_i),
        .mem_ld_unsigned_i(mem_ld_unsigned_i),
        .mem_addr_lo_i    (mem_addr_lo_i),
        .dmem_rvalid_i    (dmem_rvalid_i),
        .dmem_rdata_i     (dmem_rdata_i),
        .rf_waddr_o       (rf_waddr_o),
        .rf_wdata_o       (rf_wdata_o),
        .rf_wen_o         (rf_wen_o),
        .pending_valid_o  (pending_valid_o),
        .pending_rd_o     (pending_rd_o),
        .commit_valid_o   (commit_valid_o),
        .commit_pc_o      (commit_pc_o),
        .commit_inst_o    (commit_inst_o),
        .commit_wen_o     (commit_wen_o),
        .commit_wdest_o   (commit_wdest_o),
        .commit_wdata_o   (commit_wdata_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [63:0] pc, input logic [31:0] inst,
                         input logic [4:0] rd, input logic wen,
                         input logic [63:0] res, input logic ld,
                         input logic [1:0] sz, input logic u,
                         input logic [2:0] lo);
        mem_valid_i       = 1'b1;
        mem_pc_i          = pc;
        mem_inst_i        = inst;
        mem_rd_i          = rd;
        mem_rd_wen_i      = wen;
        mem_result_i      = res;
        mem_is_load_i     = ld;
        mem_ld_size_i     = sz;
        mem_ld_unsigned_i = u;
        mem_addr_lo_i     = lo;
    endtask

    task automatic load(input string tag, input logic [4:0] rd,
                        input logic [1:0] sz, input logic u,
                        input logic [2:0] lo, input logic [63:0] data,
                        input int waits, input logic [63:0] exp);
        drive(64'h8000_1000, 32'h0000_0003, rd, 1'b1, 64'hDEAD, 1'b1,
              sz, u, lo);
        step();
        mem_valid_i = 1'b0;
        for (int i = 0; i < waits; i++) begin
            chk({tag, "_rdy"}, 64'(mem_ready_o), 64'd0);
            chk({tag, "_pv"}, 64'(pending_valid_o), 64'd1);
            chk({tag, "_prd"}, 64'(pending_rd_o), 64'(rd));
            step();
        end
        dmem_rdata_i  = data;
        dmem_rvalid_i = 1'b1;
        step();
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = 64'd0;
        chk({tag, "_wen"}, 64'(rf_wen_o), 64'd1);
        chk({tag, "_addr"}, 64'(rf_waddr_o), 64'(rd));
        chk({tag, "_data"}, rf_wdata_o, exp);
        chk({tag, "_cdata"}, commit_wdata_o, exp);
        step();
        chk({tag, "_idle"}, 64'(commit_valid_o), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        mem_valid_i = 1'b0;
        mem_pc_i = '0;
        mem_inst_i = '0;
        mem_rd_i = '0;
        mem_rd_wen_i = 1'b0;
        mem_result_i = '0;
        mem_is_load_i = 1'b0;
        mem_ld_size_i = '0;
        mem_ld_unsigned_i = 1'b0;
        mem_addr_lo_i = '0;
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i = '0;

        step();
        chk("rst_rdy", 64'(mem_ready_o), 64'd0);
        chk("rst_wen", 64'(rf_wen_o), 64'd0);
        chk("rst_cv", 64'(commit_valid_o), 64'd0);
        chk("rst_pv", 64'(pending_valid_o), 64'd0);
        rst = 1'b0;
        step();
        chk("post_rst_rdy", 64'(mem_ready_o), 64'd1);

        // back-to-back ALU ops
        drive(64'h8000_0000, 32'h0000_0033, 5'd5, 1'b1, 64'h11, 1'b0,
              2'd0, 1'b0, 3'd0);
        step();
        chk("alu1_wen", 64'(rf_wen_o), 64'd1);
        chk("alu1_addr", 64'(rf_waddr_o), 64'd5);
        chk("alu1_data", rf_wdata_o, 64'h11);
        chk("alu1_cv", 64'(commit_valid_o), 64'd1);
        chk("alu1_rdy", 64'(mem_ready_o), 64'd1);
        drive(64'h8000_0004, 32'h0000_0133, 5'd6, 1'b1, 64'h22, 1'b0,
              2'd0, 1'b0, 3'd0);
        step();
        mem_valid_i = 1'b0;
        chk("alu2_wen", 64'(rf_wen_o), 64'd1);
        chk("alu2_addr", 64'(rf_waddr_o), 64'd6);
        chk("alu2_data", rf_wdata_o, 64'h22);
        chk("alu2_cv", 64'(commit_valid_o), 64'd1);
        chk("alu2_pc", commit_pc_o, 64'h8000_0004);
        chk("alu2_rdy", 64'(mem_ready_o), 64'd1);
        step();
        chk("alu_idle_wen", 64'(rf_wen_o), 64'd0);
        chk("alu_idle_cv", 64'(commit_valid_o), 64'd0);
        chk("alu_idle_addr", 64'(rf_waddr_o), 64'd0);

        // stray response while idle is ignored
        dmem_rvalid_i = 1'b1;
        step();
        dmem_rvalid_i = 1'b0;
        chk("stray_cv", 64'(commit_valid_o), 64'd0);
        chk("stray_rdy", 64'(mem_ready_o), 64'd1);

        load("lb", 5'd7, 2'd0, 1'b0, 3'd3, 64'h0000_0000_8000_0000, 0,
             64'hFFFF_FFFF_FFFF_FF80);
        load("lbu", 5'd7, 2'd0, 1'b1, 3'd3, 64'h0000_0000_8000_0000, 0,
             64'h80);
        load("lw", 5'd9, 2'd2, 1'b0, 3'd4, 64'h7FFF_FFFF_0000_0000, 3,
             64'h0000_0000_7FFF_FFFF);
        load("lh", 5'd11, 2'd1, 1'b0, 3'd6, 64'h8001_0000_0000_0000, 1,
             64'hFFFF_FFFF_FFFF_8001);
        load("lhu", 5'd12, 2'd1, 1'b1, 3'd7, 64'h8001_0000_0000_0000, 0,
             64'h8001);
        load("lws", 5'd13, 2'd2, 1'b0, 3'd1, 64'h1234_5678_F000_0000, 0,
             64'hFFFF_FFFF_F000_0000);
        load("ld", 5'd14, 2'd3, 1'b0, 3'd5, 64'h8123_4567_89AB_CDEF, 1,
             64'h8123_4567_89AB_CDEF);

        // write to x0 still retires
        drive(64'h8000_0010, 32'h0050_0013, 5'd0, 1'b1, 64'd5, 1'b0,
              2'd0, 1'b0, 3'd0);
        step();
        mem_valid_i = 1'b0;
        chk("x0_wen", 64'(rf_wen_o), 64'd0);
        chk("x0_cwen", 64'(commit_wen_o), 64'd0);
        chk("x0_cv", 64'(commit_valid_o), 64'd1);
        chk("x0_pc", commit_pc_o, 64'h8000_0010);
        chk("x0_inst", 64'(commit_inst_o), 64'h0050_0013);
        chk("x0_pv", 64'(pending_valid_o), 64'd0);
        step();

        // async reset while waiting for load data
        drive(64'h8000_0020, 32'h0000_2503, 5'd10, 1'b1, 64'd0, 1'b1,
              2'd2, 1'b0, 3'd0);
        step();
        mem_valid_i = 1'b0;
        chk("ar_pv_pre", 64'(pending_valid_o), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_rdy", 64'(mem_ready_o), 64'd0);
        chk("ar_pv", 64'(pending_valid_o), 64'd0);
        chk("ar_prd", 64'(pending_rd_o), 64'd0);
        chk("ar_wen", 64'(rf_wen_o), 64'd0);
        chk("ar_cv", 64'(commit_valid_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 64'h1234;
        step();
        dmem_rvalid_i = 1'b0;
        chk("ar_post_cv", 64'(commit_valid_o), 64'd0);
        chk("ar_post_wen", 64'(rf_wen_o), 64'd0);
        chk("ar_post_rdy", 64'(mem_ready_o), 64'd1);
        step();
        chk("ar_post2_cv", 64'(commit_valid_o), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
